inst_queue: RTL and testbench

Instruction FIFO between instruction fetch and the decoder. Buffers fetched instruction/PC pairs, presents one entry per cycle to the decoder as a one-cycle valid pulse when the dispatcher can accept, and flushes its contents when the decoder redirects fetch on a JAL or the reorder buffer signals a misprediction clear. It absorbs fetch latency and back-pressures fetch through an almost-full flag.

---
 rtl/inst_queue.sv | 86 ++++++++
 tb/tb_inst_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction FIFO between fetch and decode: circular buffer of {inst, pc} with flush and almost-full.
// Pop presents a registered one-cycle en_out pulse; push-to-decoder latency is 2 edges, 1 entry/cycle sustained.
module inst_queue #(
  parameter int QUEUE_SIZE_LOG    = 4,
  parameter int ALMOST_FULL_SLACK = 2,
  parameter int IDWidth           = 32,
  parameter int AddressWidth      = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    if_instqueue_en_in,
  input  logic [IDWidth-1:0]      if_instqueue_inst_in,
  input  logic [AddressWidth-1:0] if_instqueue_pc_in,
  output logic                    instqueue_if_full_out,
  input  logic                    dispatcher_instqueue_rdy_in,
  input  logic                    decoder_instqueue_rst_in,
  input  logic                    rob_instqueue_clear_in,
  output logic                    instqueue_decoder_en_out,
  output logic [IDWidth-1:0]      instqueue_decoder_inst_out,
  output logic [AddressWidth-1:0] instqueue_decoder_pc_out
);

  localparam int Size = 1 << QUEUE_SIZE_LOG;
  localparam logic [QUEUE_SIZE_LOG:0] FullThresh = (QUEUE_SIZE_LOG+1)'(Size - ALMOST_FULL_SLACK);

  logic [IDWidth-1:0]      r_inst_mem [Size];
  logic [AddressWidth-1:0] r_pc_mem   [Size];
  logic [QUEUE_SIZE_LOG-1:0] r_head;
  logic [QUEUE_SIZE_LOG-1:0] r_tail;
  logic [QUEUE_SIZE_LOG:0]   r_count;

  logic w_flush;
  logic w_pop;
  logic w_push;

  assign w_flush = decoder_instqueue_rst_in | rob_instqueue_clear_in;
  assign w_pop   = (r_count != '0) && dispatcher_instqueue_rdy_in;
  // count's MSB is set only when the queue holds exactly Size entries
  assign w_push  = if_instqueue_en_in && (!r_count[QUEUE_SIZE_LOG] || w_pop);

  assign instqueue_if_full_out = (r_count >= FullThresh);

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !w_flush && w_push) begin
      r_inst_mem[r_tail] <= if_instqueue_inst_in;
      r_pc_mem[r_tail]   <= if_instqueue_pc_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head                     <= '0;
      r_tail                     <= '0;
      r_count                    <= '0;
      instqueue_decoder_en_out   <= 1'b0;
      instqueue_decoder_inst_out <= '0;
      instqueue_decoder_pc_out   <= '0;
    end else if (rdy_in) begin
      if (w_flush) begin
        r_head                   <= '0;
        r_tail                   <= '0;
        r_count                  <= '0;
        instqueue_decoder_en_out <= 1'b0;
      end else begin
        if (w_pop) begin
          instqueue_decoder_inst_out <= r_inst_mem[r_head];
          instqueue_decoder_pc_out   <= r_pc_mem[r_head];
          instqueue_decoder_en_out   <= 1'b1;
          r_head                     <= r_head + 1'b1;
        end else begin
          instqueue_decoder_en_out <= 1'b0;
        end
        if (w_push) begin
          r_tail <= r_tail + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed and randomized checks of inst_queue against a queue-based reference model.
module tb_inst_queue;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        if_en = 1'b0;
  logic [31:0] if_inst = '0;
  logic [31:0] if_pc = '0;
  logic        full_out;
  logic        disp_rdy = 1'b0;
  logic        dec_rst = 1'b0;
  logic        rob_clr = 1'b0;
  logic        en_out;
  logic [31:0] inst_out;
  logic [31:0] pc_out;

  inst_queue dut (
    .clk_in                      (clk_in),
    .rst_in                      (rst_in),
    .rdy_in                      (rdy_in),
    .if_instqueue_en_in          (if_en),
    .if_instqueue_inst_in        (if_inst),
    .if_instqueue_pc_in          (if_pc),
    .instqueue_if_full_out       (full_out),
    .dispatcher_instqueue_rdy_in (disp_rdy),
    .decoder_instqueue_rst_in    (dec_rst),
    .rob_instqueue_clear_in      (rob_clr),
    .instqueue_decoder_en_out    (en_out),
    .instqueue_decoder_inst_out  (inst_out),
    .instqueue_decoder_pc_out    (pc_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic        m_en = 1'b0;
  logic [31:0] m_inst = '0;
  logic [31:0] m_pc = '0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] next_pc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_full();
    return q.size() >= 14;
  endfunction

  // One clock: drive inputs, advance the model on the edge, compare just after it.
  task automatic cycle(input logic rst, input logic rdy, input logic push, input logic [31:0] pc,
                       input logic disp, input logic dfl, input logic rcl);
    logic [31:0] inst;
    int          sz;
    bit          pop;
    ent_t        e;
    inst     = $urandom;
    rst_in   = rst;
    rdy_in   = rdy;
    if_en    = push;
    if_inst  = inst;
    if_pc    = pc;
    disp_rdy = disp;
    dec_rst  = dfl;
    rob_clr  = rcl;
    @(posedge clk_in);
    if (rst) begin
      q.delete();
      m_en = 1'b0; m_inst = '0; m_pc = '0;
    end else if (rdy) begin
      if (dfl || rcl) begin
        q.delete();
        m_en = 1'b0;
      end else begin
        sz  = q.size();
        pop = (sz > 0) && disp;
        assert (!(push && sz == 16 && !pop)) else begin
          miscompares++;
          $error("FAIL protocol push into full queue without pop");
        end
        if (pop) begin
          e = q.pop_front();
          m_en = 1'b1; m_inst = e.inst; m_pc = e.pc;
        end else begin
          m_en = 1'b0;
        end
        if (push && (sz < 16 || pop)) q.push_back('{inst, pc});
      end
    end
    #1;
    chk("en_out", {31'd0, en_out}, {31'd0, m_en});
    chk("pc_out", pc_out, m_pc);
    chk("inst_out", inst_out, m_inst);
    chk("full_out", {31'd0, full_out}, {31'd0, m_full()});
    chk("count", {27'd0, dut.r_count}, 32'(q.size()));
  endtask

  task automatic push_one(input logic disp);
    cycle(0, 1, 1, next_pc, disp, 0, 0);
    next_pc += 4;
  endtask

  task automatic idle(input int n, input logic disp);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 32'h0, disp, 0, 0);
  endtask

  initial begin
    // reset state
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 32'h44, 1, 0, 0);

    // three consecutive pushes with dispatcher ready
    next_pc = 32'h0;
    push_one(1); push_one(1); push_one(1);
    idle(4, 1);

    // fill 14 with dispatcher stalled, then drain
    next_pc = 32'h1000;
    for (int i = 0; i < 14; i++) push_one(0);
    idle(16, 1);

    // 20 entries with interleaved pops to wrap tail
    next_pc = 32'h2000;
    for (int i = 0; i < 20; i++) begin
      if (!m_full()) push_one($urandom_range(0, 1));
      else idle(1, 1);
    end
    idle(20, 1);

    // exactly full, then simultaneous push and pop at full
    next_pc = 32'h3000;
    for (int i = 0; i < 16; i++) push_one(0);
    push_one(1);
    push_one(1);
    idle(18, 1);

    // push and pop at empty on the same edge
    push_one(1);
    idle(3, 1);

    // JAL flush with a simultaneous push
    next_pc = 32'h4000;
    for (int i = 0; i < 5; i++) push_one(0);
    idle(1, 1);
    cycle(0, 1, 1, 32'hdead0, 1, 1, 0);
    idle(4, 1);

    // rdy_in low mid-stream
    next_pc = 32'h5000;
    for (int i = 0; i < 6; i++) push_one(1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'hbad0, 1, 0, 0);
    idle(8, 1);

    // reset with 8 queued, then a single push
    next_pc = 32'h6000;
    for (int i = 0; i < 8; i++) push_one(0);
    cycle(1, 1, 0, 0, 1, 0, 0);
    cycle(0, 1, 1, 32'h100, 1, 0, 0);
    idle(3, 1);

    // randomized traffic
    next_pc = 32'h8000;
    for (int i = 0; i < 600; i++) begin
      logic r, rd, p, d, df, rc;
      r  = ($urandom_range(0, 99) == 0);
      rd = ($urandom_range(0, 4) != 0);
      p  = !m_full() && ($urandom_range(0, 2) != 0);
      d  = ($urandom_range(0, 3) != 0);
      df = m_en && ($urandom_range(0, 9) == 0);
      rc = ($urandom_range(0, 39) == 0);
      cycle(r, rd, p, next_pc, d, df, rc);
      next_pc += 4;
    end
    idle(20, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
